// File: rtl/param_reg_multimode.sv
// General-purpose WIDTH-bit state element: load, shift, rotate and up/down count,
// with synchronous reset/clear/set-all, registered serial-out and terminal-count flags.
module param_reg_multimode #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_LOAD   = 3'b001,
        MODE_SHL    = 3'b010,
        MODE_SHR    = 3'b011,
        MODE_ROL    = 3'b100,
        MODE_ROR    = 3'b101,
        MODE_UP     = 3'b110,
        MODE_DOWN   = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_reg, q_next;
    logic             sout_reg, sout_next;
    logic             tc_reg, tc_next;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);

    // tc defaults low so it is a single-cycle pulse unless a boundary event recurs.
    always_comb begin
        q_next    = q_reg;
        sout_next = sout_reg;
        tc_next   = 1'b0;
        if (clr) begin
            q_next = ALL_ZERO;
        end else if (set) begin
            q_next = ALL_ONES;
        end else if (en) begin
            case (mode_sel)
                MODE_HOLD: q_next = q_reg;
                MODE_LOAD: q_next = d;
                MODE_SHL: begin
                    q_next    = {q_reg[WIDTH-2:0], sin};
                    sout_next = q_reg[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next    = {sin, q_reg[WIDTH-1:1]};
                    sout_next = q_reg[0];
                end
                MODE_ROL: begin
                    q_next    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    sout_next = q_reg[WIDTH-1];
                end
                MODE_ROR: begin
                    q_next    = {q_reg[0], q_reg[WIDTH-1:1]};
                    sout_next = q_reg[0];
                end
                MODE_UP: begin
                    if (q_reg == ALL_ONES) begin
                        tc_next = 1'b1;
                        q_next  = SATURATE ? q_reg : ALL_ZERO;
                    end else begin
                        q_next = q_reg + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q_reg == ALL_ZERO) begin
                        tc_next = 1'b1;
                        q_next  = SATURATE ? q_reg : ALL_ONES;
                    end else begin
                        q_next = q_reg - ONE;
                    end
                end
                default: q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg    <= RESET_VAL;
            sout_reg <= 1'b0;
            tc_reg   <= 1'b0;
        end else begin
            q_reg    <= q_next;
            sout_reg <= sout_next;
            tc_reg   <= tc_next;
        end
    end

    assign q    = q_reg;
    assign sout = sout_reg;
    assign tc   = tc_reg;
    assign zero = (q_reg == ALL_ZERO);

endmodule
